// File: rtl/uart_rx_ingress_if.sv
// FIFO write port between the UART receiver and the ingress FIFO.
//   fifo_din    received byte, valid while fifo_wr_en is high
//   fifo_wr_en  one-cycle write strobe
//   fifo_full   FIFO cannot accept a byte; the receiver drops it instead
// master = receiver side, slave = FIFO side.
interface uart_rx_ingress_if;
    logic [7:0] fifo_din;
    logic       fifo_wr_en;
    logic       fifo_full;

    modport master (output fifo_din, output fifo_wr_en, input fifo_full);
    modport slave  (input fifo_din, input fifo_wr_en, output fifo_full);
endinterface

// File: rtl/uart_rx_ingress.sv
// 8N1 UART receiver feeding the host->FPGA ingress FIFO.
// Samples the asynchronous rxd pin through a 2-FF synchronizer, checks the
// start and stop bits, and pushes each good byte into the FIFO write port.
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   uart_rxd      asynchronous serial input, idle high
//   fifo          FIFO write port (fifo_din / fifo_wr_en out, fifo_full in)
//   frame_err     one-cycle pulse when the stop bit is sampled low
//   overflow      sticky flag: a byte was dropped because the FIFO was full
//   overflow_clr  clears overflow (a simultaneous new drop keeps it set)
//   drop_count    saturating count of dropped bytes, cleared only by rst
//   rx_busy       high whenever the receiver is not idle
//
// state   | meaning
// S_IDLE  | line idle, waiting for a falling edge
// S_START | half a bit in, confirming the start bit is still low
// S_DATA  | sampling the 8 data bits at mid-bit, LSB first
// S_STOP  | sampling the stop bit, then write / drop / frame error
// S_BREAK | stop bit was low; wait for the line to return high
module uart_rx_ingress #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DROP_CNT_W   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  uart_rxd,
    uart_rx_ingress_if.master     fifo,
    output logic                  frame_err,
    output logic                  overflow,
    input  logic                  overflow_clr,
    output logic [DROP_CNT_W-1:0] drop_count,
    output logic                  rx_busy
);

    localparam int HALF  = CLKS_PER_BIT / 2;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t            state;
    logic              rxd_meta;
    logic              rxd_s;
    logic [CNT_W-1:0]  cnt;
    logic [2:0]        bit_idx;
    logic [7:0]        shreg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= S_IDLE;
            rxd_meta        <= 1'b1;
            rxd_s           <= 1'b1;
            cnt             <= '0;
            bit_idx         <= '0;
            shreg           <= '0;
            fifo.fifo_din   <= '0;
            fifo.fifo_wr_en <= 1'b0;
            frame_err       <= 1'b0;
            overflow        <= 1'b0;
            drop_count      <= '0;
        end else begin
            rxd_meta        <= uart_rxd;
            rxd_s           <= rxd_meta;
            fifo.fifo_wr_en <= 1'b0;
            frame_err       <= 1'b0;

            // A drop in this same cycle overrides the clear further down.
            if (overflow_clr) overflow <= 1'b0;

            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (!rxd_s) state <= S_START;
                end

                S_START: begin
                    if (cnt == HALF_LAST) begin
                        cnt <= '0;
                        if (!rxd_s) begin
                            state   <= S_DATA;
                            bit_idx <= '0;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                S_DATA: begin
                    if (cnt == CNT_LAST) begin
                        cnt            <= '0;
                        shreg[bit_idx] <= rxd_s;
                        if (bit_idx == 3'd7) state <= S_STOP;
                        else                 bit_idx <= bit_idx + 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                // Decided at mid stop bit, so idle is re-entered half a bit
                // early and a start bit right after the stop bit is caught.
                S_STOP: begin
                    if (cnt == CNT_LAST) begin
                        cnt <= '0;
                        if (rxd_s) begin
                            if (!fifo.fifo_full) begin
                                fifo.fifo_din   <= shreg;
                                fifo.fifo_wr_en <= 1'b1;
                            end else begin
                                overflow <= 1'b1;
                                if (!(&drop_count)) drop_count <= drop_count + 1'b1;
                            end
                            state <= S_IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= S_BREAK;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                S_BREAK: begin
                    cnt <= '0;
                    if (rxd_s) state <= S_IDLE;
                end

                default: begin
                    cnt   <= '0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign rx_busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_ingress.sv
module tb_uart_rx_ingress;

    localparam int CPB  = 16;
    localparam int HALF = CPB / 2;
    localparam int LAT  = 2 + HALF + 9 * CPB + 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        uart_rxd;
    logic        frame_err;
    logic        overflow;
    logic        overflow_clr;
    logic [15:0] drop_count;
    logic        rx_busy;

    uart_rx_ingress_if ff_if ();

    uart_rx_ingress #(.CLKS_PER_BIT(CPB), .DROP_CNT_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .uart_rxd     (uart_rxd),
        .fifo         (ff_if.master),
        .frame_err    (frame_err),
        .overflow     (overflow),
        .overflow_clr (overflow_clr),
        .drop_count   (drop_count),
        .rx_busy      (rx_busy)
    );

    always #5 clk = ~clk;

    int          cyc = 0;
    logic [7:0]  wr_q[$];
    int          wr_cyc_q[$];
    int          ferr_cnt = 0;
    int          ov_hi = 0;
    int          n_assert = 0;
    int          n_fail = 0;
    int          start_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst && ff_if.fifo_wr_en) begin
            wr_q.push_back(ff_if.fifo_din);
            wr_cyc_q.push_back(cyc);
        end
        if (!rst && frame_err) ferr_cnt <= ferr_cnt + 1;
        if (!rst && overflow)  ov_hi    <= ov_hi + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clocks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        uart_rxd = b;
        clocks(CPB);
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop);
        start_cyc = cyc;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(data[i]);
        send_bit(stop);
    endtask

    int wr_base;
    int ferr_base;
    int ov_base;

    initial begin
        rst          = 1'b1;
        uart_rxd     = 1'b1;
        overflow_clr = 1'b0;
        ff_if.fifo_full = 1'b0;
        clocks(3);
        check("rst_din",   32'(ff_if.fifo_din), 32'h00);
        check("rst_wr_en", 32'(ff_if.fifo_wr_en), 32'h0);
        check("rst_ferr",  32'(frame_err), 32'h0);
        check("rst_ovf",   32'(overflow), 32'h0);
        check("rst_drop",  32'(drop_count), 32'h0);
        check("rst_busy",  32'(rx_busy), 32'h0);
        rst = 1'b0;
        clocks(5);

        // 1: single byte, latency from pin falling edge
        wr_base = wr_q.size();
        send_frame(8'hA5, 1'b1);
        clocks(20);
        check("t1_count", 32'(wr_q.size() - wr_base), 32'd1);
        check("t1_data",  32'(wr_q[wr_base]), 32'hA5);
        check("t1_lat",   32'(wr_cyc_q[wr_base] - start_cyc), 32'(LAT));
        check("t1_ferr",  32'(ferr_cnt), 32'd0);
        check("t1_busy",  32'(rx_busy), 32'h0);

        // 2: back-to-back frames
        wr_base = wr_q.size();
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h55, 1'b1);
        clocks(20);
        check("t2_count", 32'(wr_q.size() - wr_base), 32'd3);
        check("t2_b0",    32'(wr_q[wr_base]),     32'h00);
        check("t2_b1",    32'(wr_q[wr_base + 1]), 32'hFF);
        check("t2_b2",    32'(wr_q[wr_base + 2]), 32'h55);

        // 3: short glitch is rejected silently
        wr_base = wr_q.size();
        uart_rxd = 1'b0;
        clocks(4);
        check("t3_busy_hi", 32'(rx_busy), 32'h1);
        uart_rxd = 1'b1;
        clocks(HALF + 3);
        check("t3_busy_lo", 32'(rx_busy), 32'h0);
        check("t3_count",   32'(wr_q.size() - wr_base), 32'd0);
        check("t3_ferr",    32'(ferr_cnt), 32'd0);

        // 4: framing error, held break, then recovery
        wr_base   = wr_q.size();
        ferr_base = ferr_cnt;
        send_frame(8'h3C, 1'b0);
        uart_rxd = 1'b0;
        clocks(40);
        uart_rxd = 1'b1;
        clocks(20);
        check("t4_ferr",     32'(ferr_cnt - ferr_base), 32'd1);
        check("t4_no_write", 32'(wr_q.size() - wr_base), 32'd0);
        check("t4_busy",     32'(rx_busy), 32'h0);
        send_frame(8'h11, 1'b1);
        clocks(20);
        check("t4_count",    32'(wr_q.size() - wr_base), 32'd1);
        check("t4_data",     32'(wr_q[wr_base]), 32'h11);
        check("t4_ferr_end", 32'(ferr_cnt - ferr_base), 32'd1);

        // 5: drops on full FIFO, overflow clear, set-wins-over-clear
        wr_base = wr_q.size();
        ff_if.fifo_full = 1'b1;
        send_frame(8'h7E, 1'b1);
        clocks(20);
        ff_if.fifo_full = 1'b0;
        check("t5_no_write", 32'(wr_q.size() - wr_base), 32'd0);
        check("t5_ovf",      32'(overflow), 32'h1);
        check("t5_drop1",    32'(drop_count), 32'd1);
        check("t5_din_hold", 32'(ff_if.fifo_din), 32'h11);
        overflow_clr = 1'b1;
        clocks(1);
        overflow_clr = 1'b0;
        check("t5_ovf_clr",  32'(overflow), 32'h0);
        ov_base = ov_hi;
        overflow_clr = 1'b1;
        ff_if.fifo_full = 1'b1;
        send_frame(8'h81, 1'b1);
        clocks(20);
        overflow_clr = 1'b0;
        ff_if.fifo_full = 1'b0;
        check("t5_set_wins", 32'(ov_hi - ov_base), 32'd1);
        check("t5_drop2",    32'(drop_count), 32'd2);
        check("t5_no_write2", 32'(wr_q.size() - wr_base), 32'd0);

        // 6: reset during bit 3 of 0xF0 (line low), then a clean byte
        wr_base   = wr_q.size();
        ferr_base = ferr_cnt;
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b0);
        uart_rxd = 1'b0;
        clocks(HALF);
        rst      = 1'b1;
        uart_rxd = 1'b1;
        clocks(1);
        check("t6_din",   32'(ff_if.fifo_din), 32'h00);
        check("t6_wr_en", 32'(ff_if.fifo_wr_en), 32'h0);
        check("t6_ferr",  32'(frame_err), 32'h0);
        check("t6_ovf",   32'(overflow), 32'h0);
        check("t6_drop",  32'(drop_count), 32'd0);
        check("t6_busy",  32'(rx_busy), 32'h0);
        rst = 1'b0;
        clocks(40);
        check("t6_no_write", 32'(wr_q.size() - wr_base), 32'd0);
        check("t6_no_ferr",  32'(ferr_cnt - ferr_base), 32'd0);
        send_frame(8'hC3, 1'b1);
        clocks(20);
        check("t6_count", 32'(wr_q.size() - wr_base), 32'd1);
        check("t6_data",  32'(wr_q[wr_base]), 32'hC3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
